// File: rtl/product_display_pkg.sv
// Shared types and constants for the product display back-end:
// widths, FSM encoding and active-low seven-segment patterns.
package product_display_pkg;

  localparam int P_W    = 12;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;

  // Segment order {g,f,e,d,c,b,a}, 0 = lit.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/product_display_bin2bcd_seq.sv
// Sequential shift-add-3 converter: 12-bit magnitude to four BCD nibbles.
// The first step is applied on the start edge itself (adding 3 to a
// cleared BCD field is a no-op), so the result is ready 12 edges later.
module bin2bcd_seq
  import product_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [P_W-1:0]   mag,
  output logic [BCD_W-1:0] bcd,
  output logic             valid
);

  localparam int SR_W = BCD_W + P_W;

  logic [SR_W-1:0] sr_p0;
  logic [3:0]      bit_cnt;
  logic            busy;

  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[P_W+4*i +: 4] >= 4'd5)
        t[P_W+4*i +: 4] = t[P_W+4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      bit_cnt <= 4'd0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        bit_cnt <= 4'd1;
      end else if (busy) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'(P_W - 1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  // Shift stage: {bcd, mag} register
  always_ff @(posedge clk) begin
    if (start)
      sr_p0 <= dabble_step({{BCD_W{1'b0}}, mag});
    else if (busy)
      sr_p0 <= dabble_step(sr_p0);
  end

  assign bcd = sr_p0[SR_W-1 -: BCD_W];

endmodule

// File: rtl/product_display.sv
// Captures a signed product, converts it to BCD and scans it onto a
// 4-digit common-anode seven-segment display with a separate sign LED.
module product_display
  import product_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [P_W-1:0] p_in,
  input  logic           p_valid,
  output logic           in_ready,
  output logic           done,
  output logic           neg,
  output logic [3:0]     an,
  output logic [6:0]     seg
);

  localparam int RC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

  state_t                  state;
  logic                    sign_q;
  logic signed [P_W-1:0]   p_s;
  logic        [P_W-1:0]   mag;
  logic                    start;
  logic                    commit;
  logic        [BCD_W-1:0] bcd;
  logic                    bcd_valid;
  logic        [BCD_W-1:0] disp_q;
  logic        [BCD_W-1:0] disp_nxt;
  logic        [RC_W-1:0]  ref_cnt;
  logic                    wrap;
  logic        [1:0]       idx;
  logic        [1:0]       idx_nxt;
  logic        [3:0]       nib;
  logic                    blank;
  logic        [6:0]       seg_nxt;
  logic        [3:0]       an_nxt;

  // -2048 negates to itself, whose unsigned reading is the wanted 2048.
  assign p_s    = p_in;
  assign mag    = p_s[P_W-1] ? $unsigned(-p_s) : p_in;
  assign start  = (state == IDLE) && in_ready && p_valid;
  assign commit = (state == COMMIT);
  assign wrap   = (ref_cnt == RC_LAST);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mag   (mag),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

  always_ff @(posedge clk) begin
    if (start)
      sign_q <= p_in[P_W-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      done     <= 1'b0;
      neg      <= 1'b0;
      disp_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            in_ready <= 1'b0;
            state    <= CONVERT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CONVERT: begin
          if (bcd_valid)
            state <= COMMIT;
        end
        COMMIT: begin
          disp_q <= bcd;
          neg    <= sign_q && (bcd != '0);
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Look ahead to the committed digits and next index so a new value and
  // an index wrap landing on the same edge are both reflected at once.
  always_comb begin
    disp_nxt = commit ? bcd : disp_q;
    idx_nxt  = wrap ? idx + 2'd1 : idx;
    nib      = disp_nxt[4*idx_nxt +: 4];
    blank    = 1'b0;
    if (BLANK_LZ != 0) begin
      case (idx_nxt)
        2'd1:    blank = (disp_nxt[15:4]  == 12'd0);
        2'd2:    blank = (disp_nxt[15:8]  == 8'd0);
        2'd3:    blank = (disp_nxt[15:12] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
    seg_nxt = blank ? SEG_BLANK : seg_decode(nib);
    an_nxt  = ~(4'b0001 << idx_nxt);
  end

  // Scan stage: registered digit enable and segment drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt <= '0;
      idx     <= 2'd0;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
    end else begin
      ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
      idx     <= idx_nxt;
      an      <= an_nxt;
      seg     <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_product_display.sv
// Directed bench for product_display: two instances (leading-zero blanking
// on and off) driven from one stimulus, with a short refresh divider.
module tb_product_display;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] p_in;
  logic        p_valid;
  logic        in_ready, done, neg;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        in_ready_b, done_b, neg_b;
  logic [3:0]  an_b;
  logic [6:0]  seg_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] p;
    logic        nneg;
    logic [27:0] segs_a;
    logic [27:0] segs_b;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  product_display #(.REFRESH_DIV(RD), .BLANK_LZ(1)) dut_a (
    .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid),
    .in_ready(in_ready), .done(done), .neg(neg), .an(an), .seg(seg)
  );

  product_display #(.REFRESH_DIV(RD), .BLANK_LZ(0)) dut_b (
    .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid),
    .in_ready(in_ready_b), .done(done_b), .neg(neg_b), .an(an_b), .seg(seg_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample one full scan period; each slot holds the pattern seen for that digit.
  task automatic read_scan(output logic [27:0] sa, output logic [27:0] sb);
    sa = 'x;
    sb = 'x;
    for (int c = 0; c < 4*RD; c++) begin
      @(posedge clk);
      @(negedge clk);
      case (an)
        4'b1110: sa[6:0]   = seg;
        4'b1101: sa[13:7]  = seg;
        4'b1011: sa[20:14] = seg;
        4'b0111: sa[27:21] = seg;
        default: sa = 'x;
      endcase
      case (an_b)
        4'b1110: sb[6:0]   = seg_b;
        4'b1101: sb[13:7]  = seg_b;
        4'b1011: sb[20:14] = seg_b;
        4'b0111: sb[27:21] = seg_b;
        default: sb = 'x;
      endcase
    end
  endtask

  // Strobe one value and wait (bounded) for done; lat counts edges from the capture edge.
  task automatic capture(input logic [11:0] v, input logic prev_neg, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    p_in    = v;
    p_valid = 1'b1;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      p_valid = 1'b0;
      if (lat == 7) check("hold_neg_mid_convert", neg, prev_neg);
      if (done) got = 1'b1;
    end
    check("done_b_with_a", done_b, got);
    check("in_ready_low_at_done", in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("in_ready_after_done", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          dones;
    int          done_at;
    int          ready_bad;
    logic        prev_neg;
    logic [27:0] sa, sb;

    vecs[0] = '{12'h400, 1'b0, {7'h79, 7'h40, 7'h24, 7'h19}, {7'h79, 7'h40, 7'h24, 7'h19}};
    vecs[1] = '{12'hC20, 1'b1, {7'h7F, 7'h10, 7'h10, 7'h24}, {7'h40, 7'h10, 7'h10, 7'h24}};
    vecs[2] = '{12'h800, 1'b1, {7'h24, 7'h40, 7'h19, 7'h00}, {7'h24, 7'h40, 7'h19, 7'h00}};
    vecs[3] = '{12'h007, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h40, 7'h40, 7'h40, 7'h78}};
    vecs[4] = '{12'h000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{12'hFFF, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79}, {7'h40, 7'h40, 7'h40, 7'h79}};
    vecs[6] = '{12'h7FF, 1'b0, {7'h24, 7'h40, 7'h19, 7'h78}, {7'h24, 7'h40, 7'h19, 7'h78}};
    vecs[7] = '{12'h064, 1'b0, {7'h7F, 7'h79, 7'h40, 7'h40}, {7'h40, 7'h79, 7'h40, 7'h40}};
    vecs[8] = '{12'hFFB, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, {7'h40, 7'h40, 7'h40, 7'h12}};

    reset   = 1'b0;
    p_in    = 12'd0;
    p_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'h7F);
    check("rst_neg", neg, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_an_b", an_b, 4'b1111);

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("scan0_an", an, 4'b1110);
    check("scan0_seg", seg, 7'h40);
    check("scan0_seg_b", seg_b, 7'h40);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scan1_an", an, 4'b1101);
    check("scan1_seg", seg, 7'h7F);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scan2_an", an, 4'b1011);
    check("scan2_seg", seg, 7'h7F);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scan3_an", an, 4'b0111);
    check("scan3_seg", seg, 7'h7F);
    check("scan3_seg_b", seg_b, 7'h40);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scan4_an", an, 4'b1110);

    prev_neg = 1'b0;
    for (int i = 0; i < 9; i++) begin
      capture(vecs[i].p, prev_neg, lat);
      check("latency", lat, 14);
      read_scan(sa, sb);
      check("digits_blank_lz", sa, vecs[i].segs_a);
      check("digits_all", sb, vecs[i].segs_b);
      check("neg", neg, vecs[i].nneg);
      check("neg_b", neg_b, vecs[i].nneg);
      prev_neg = vecs[i].nneg;
    end

    // A second strobe 5 cycles into a conversion must be dropped.
    dones     = 0;
    done_at   = 0;
    ready_bad = 0;
    @(negedge clk);
    p_in    = 12'h07B;
    p_valid = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      p_valid = (e == 5);
      if (e == 5) p_in = 12'h1C8;
      if (done) begin
        dones++;
        done_at = e;
      end
      if (e <= 14 && in_ready) ready_bad++;
    end
    check("ignored_done_count", dones, 1);
    check("ignored_done_at", done_at, 14);
    check("ignored_in_ready_low", ready_bad, 0);
    read_scan(sa, sb);
    check("ignored_digits", sa, {7'h7F, 7'h79, 7'h24, 7'h30});
    check("ignored_digits_b", sb, {7'h40, 7'h79, 7'h24, 7'h30});

    // Show a negative value, then reset partway through the next conversion.
    capture(12'hFFF, 1'b0, lat);
    check("pre_abort_latency", lat, 14);
    check("pre_abort_neg", neg, 1'b1);
    @(negedge clk);
    p_in    = 12'h400;
    p_valid = 1'b1;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
      p_valid = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("abort_an", an, 4'b1111);
    check("abort_seg", seg, 7'h7F);
    check("abort_neg", neg, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_done", done, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    read_scan(sa, sb);
    check("abort_digits", sa, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    check("abort_digits_b", sb, {7'h40, 7'h40, 7'h40, 7'h40});
    check("abort_neg_after", neg, 1'b0);

    capture(12'hFFB, 1'b0, lat);
    check("fresh_latency", lat, 14);
    read_scan(sa, sb);
    check("fresh_digits", sa, {7'h7F, 7'h7F, 7'h7F, 7'h12});
    check("fresh_neg", neg, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
